dispatch_queue: RTL and testbench

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_queue.sv | 99 +++++++++
 tb/tb_dispatch_queue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// Dispatch queue: circular buffer between fetch and the OOO core, N-wide enqueue and dispatch.
// New entries reach the id outputs one cycle after enqueue; structural_hazard stalls dispatch, squash flushes.
module dispatch_queue #(
    parameter int N     = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N-1:0]            if_valid,
    input  logic [N*XLEN-1:0]       if_inst,
    input  logic [N*XLEN-1:0]       if_pc,
    output logic                    if_ready,
    input  logic                    structural_hazard,
    input  logic                    squash,
    output logic [N-1:0]            id_valid,
    output logic [N*XLEN-1:0]       id_inst,
    output logic [N*XLEN-1:0]       id_pc,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_inst [DEPTH];
    logic [XLEN-1:0] r_pc   [DEPTH];

    logic            w_enq;
    logic [CW-1:0]   w_enq_n;
    logic [CW-1:0]   w_deq_n;
    logic [PW-1:0]   w_wr_idx [N];

    // Readiness looks only at the registered count, never at this cycle's dispatch.
    assign if_ready = (r_count <= CW'(DEPTH - N));
    assign w_enq    = if_ready && !squash;
    assign count    = r_count;

    // Each valid slot lands at tail plus the number of valid slots older than it.
    always_comb begin
        w_enq_n = '0;
        for (int i = 0; i < N; i++) begin
            w_wr_idx[i] = r_tail + PW'(w_enq_n);
            if (if_valid[i]) begin
                w_enq_n = w_enq_n + CW'(1);
            end
        end
        if (!w_enq) begin
            w_enq_n = '0;
        end
    end

    always_comb begin
        w_deq_n = '0;
        if (!structural_hazard && !squash) begin
            w_deq_n = (r_count < CW'(N)) ? r_count : CW'(N);
        end
    end

    always_comb begin
        id_valid = '0;
        id_inst  = '0;
        id_pc    = '0;
        for (int i = 0; i < N; i++) begin
            id_valid[i]              = !squash && (r_count > CW'(i));
            id_inst[i*XLEN +: XLEN]  = r_inst[r_head + PW'(i)];
            id_pc[i*XLEN +: XLEN]    = r_pc[r_head + PW'(i)];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_deq_n);
            r_tail  <= r_tail + PW'(w_enq_n);
            r_count <= r_count + w_enq_n - w_deq_n;
        end
    end

    // Payload carries no validity of its own, so it is left unreset.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            for (int i = 0; i < N; i++) begin
                if (if_valid[i]) begin
                    r_inst[w_wr_idx[i]] <= if_inst[i*XLEN +: XLEN];
                    r_pc[w_wr_idx[i]]   <= if_pc[i*XLEN +: XLEN];
                end
            end
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized bench for dispatch_queue against a FIFO-of-entries reference model.
module tb_dispatch_queue;
    localparam int N     = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                  clock;
    logic                  reset;
    logic [N-1:0]          if_valid;
    logic [N*XLEN-1:0]     if_inst;
    logic [N*XLEN-1:0]     if_pc;
    logic                  if_ready;
    logic                  structural_hazard;
    logic                  squash;
    logic [N-1:0]          id_valid;
    logic [N*XLEN-1:0]     id_inst;
    logic [N*XLEN-1:0]     id_pc;
    logic [CW-1:0]         count;

    typedef struct {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_vec;
    int   n_err;

    dispatch_queue #(.N(N), .DEPTH(DEPTH), .XLEN(XLEN)) u_dut (
        .clock             (clock),
        .reset             (reset),
        .if_valid          (if_valid),
        .if_inst           (if_inst),
        .if_pc             (if_pc),
        .if_ready          (if_ready),
        .structural_hazard (structural_hazard),
        .squash            (squash),
        .id_valid          (id_valid),
        .id_inst           (id_inst),
        .id_pc             (id_pc),
        .count             (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic sq);
        logic [N-1:0] exp_v;
        int           sz;
        sz = q.size();
        exp_v = '0;
        for (int i = 0; i < N; i++) begin
            exp_v[i] = !sq && (sz > i);
        end
        chk("count", 64'(count), 64'(sz));
        chk("if_ready", 64'(if_ready), 64'((DEPTH - sz) >= N));
        chk("id_valid", 64'(id_valid), 64'(exp_v));
        for (int i = 0; i < N; i++) begin
            if (exp_v[i]) begin
                chk("id_pc", 64'(id_pc[i*XLEN +: XLEN]), 64'(q[i].pc));
                chk("id_inst", 64'(id_inst[i*XLEN +: XLEN]), 64'(q[i].inst));
            end
        end
    endtask

    // Called at a negedge: drive, check the combinational view, advance the model, wait one cycle.
    task automatic cycle(input logic [N-1:0] v, input logic hz, input logic sq);
        ent_t slot [N];
        bit   rdy;
        for (int i = 0; i < N; i++) begin
            slot[i].inst = $urandom;
            slot[i].pc   = $urandom & 32'hFFFF_FFFC;
            if_inst[i*XLEN +: XLEN] = slot[i].inst;
            if_pc[i*XLEN +: XLEN]   = slot[i].pc;
        end
        if_valid          = v;
        structural_hazard = hz;
        squash            = sq;
        #1;
        check_outputs(sq);
        rdy = (DEPTH - q.size()) >= N;
        if (sq) begin
            q.delete();
        end else begin
            if (!hz) begin
                for (int k = 0; k < N; k++) begin
                    if (q.size() > 0) void'(q.pop_front());
                end
            end
            if (rdy) begin
                for (int i = 0; i < N; i++) begin
                    if (v[i]) q.push_back(slot[i]);
                end
            end
        end
        @(negedge clock);
    endtask

    initial begin
        int p_hz;
        int p_sq;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        if_valid = '0;
        if_inst = '0;
        if_pc = '0;
        structural_hazard = 1'b0;
        squash = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_if_ready", 64'(if_ready), 64'd1);
        @(negedge clock);
        reset = 1'b1;

        // Directed: pair pass-through, fill to full with overflow group, drain, compaction.
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(2'b11, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b10, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        // Squash with a pending enqueue on a partly filled queue.
        for (int k = 0; k < 3; k++) cycle(2'b11, 1'b1, 1'b0);
        cycle(2'b11, 1'b0, 1'b1);
        cycle(2'b00, 1'b1, 1'b0);

        for (int ph = 0; ph < 6; ph++) begin
            p_hz = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 60 : 90;
            p_sq = (ph < 3) ? 0 : 4;
            for (int c = 0; c < 300; c++) begin
                cycle(N'($urandom_range(0, (1 << N) - 1)),
                      $urandom_range(0, 99) < p_hz,
                      $urandom_range(0, 99) < p_sq);
            end
        end

        // Asynchronous reset mid-cycle with three entries queued.
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b11, 1'b1, 1'b0);
        cycle(2'b01, 1'b1, 1'b0);
        chk("pre_arst_count", 64'(count), 64'd3);
        if_valid = '0;
        structural_hazard = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_id_valid", 64'(id_valid), 64'd0);
        chk("arst_if_ready", 64'(if_ready), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 100; c++) begin
            cycle(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 99) < 40, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
